// File: rtl/rvx_uart_rx_capture.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO on a valid/ready stream.
// Optional feature macro: RVX_UART_RX_PARITY_EN (8E1 frames with parity_error reporting).
module rvx_uart_rx_capture #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               uart_rx,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               frame_error,
  output logic                               parity_error,
  output logic                               overrun
);

  localparam int unsigned CPB   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Line synchronizer; resets to the idle level
  logic sync1, rxs;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             push_q, push_n;
  logic             fe_n;
`ifdef RVX_UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
  logic             pe_n;
`endif

  // Frame FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_WAIT_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      push_q      <= 1'b0;
      frame_error <= 1'b0;
`ifdef RVX_UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      push_q      <= push_n;
      frame_error <= fe_n;
`ifdef RVX_UART_RX_PARITY_EN
      par_bad      <= par_bad_n;
      parity_error <= pe_n;
`endif
    end
  end

`ifndef RVX_UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  // Frame FSM: next state; all samples taken at mid-bit
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    push_n  = 1'b0;
    fe_n    = 1'b0;
`ifdef RVX_UART_RX_PARITY_EN
    par_bad_n = par_bad;
    pe_n      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_n   = '0;
          shift_n = {rxs, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef RVX_UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef RVX_UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_n     = '0;
          par_bad_n = (^shift) ^ rxs;
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_n = '0;
          if (!rxs) begin
            fe_n    = 1'b1;
            state_n = S_WAIT_IDLE;
          end else begin
`ifdef RVX_UART_RX_PARITY_EN
            pe_n   = par_bad;
            push_n = ~par_bad;
`else
            push_n = 1'b1;
`endif
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_n = '0;
        if (rxs) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [LVL_W-1:0] level_n;
  logic [7:0]       head_n;
  logic             pop_c, full_c, wr_en_c, ovf_c;

  // FIFO control; head byte is precomputed so rx_data stays registered
  always_comb begin
    pop_c    = rx_valid & rx_ready;
    full_c   = (fifo_level == LVL_W'(FIFO_DEPTH));
    wr_en_c  = push_q & (~full_c | pop_c);
    ovf_c    = push_q & full_c & ~pop_c;
    rd_ptr_n = pop_c   ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_n = wr_en_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    level_n  = fifo_level;
    if (wr_en_c && !pop_c)      level_n = fifo_level + LVL_W'(1);
    else if (!wr_en_c && pop_c) level_n = fifo_level - LVL_W'(1);
    if (level_n == '0)                         head_n = 8'h00;
    else if (wr_en_c && (rd_ptr_n == wr_ptr))  head_n = shift;
    else                                       head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clock) begin
    if (wr_en_c) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      fifo_level <= level_n;
      rx_valid   <= (level_n != '0);
      rx_data    <= head_n;
      overrun    <= ovf_c;
    end
  end

endmodule

// File: tb/tb_rvx_uart_rx_capture.sv
// Directed bench for rvx_uart_rx_capture at 16 clocks per bit; builds with or without RVX_UART_RX_PARITY_EN.
module tb_rvx_uart_rx_capture;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned CPB    = CLK_HZ / BAUD;
  localparam int unsigned DEPTH  = 16;
`ifdef RVX_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [4:0] fifo_level;
  logic       frame_error;
  logic       parity_error;
  logic       overrun;

  rvx_uart_rx_capture #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE      (BAUD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_level  (fifo_level),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] rx_log[$];
  int         rd_idx = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         ov_cnt = 0;
  int         max_level = 0;

  // Consumer-side monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid && rx_ready) rx_log.push_back(rx_data);
      if (frame_error)  fe_cnt++;
      if (parity_error) pe_cnt++;
      if (overrun)      ov_cnt++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    tick();
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    if (PAR_EN) begin
      uart_rx = (^b) ^ par_flip;
      repeat (CPB) tick();
    end
    uart_rx = stop_bit;
    repeat (CPB) tick();
    uart_rx = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int got;
    if (rd_idx < rx_log.size()) got = int'(rx_log[rd_idx]);
    else got = -1;
    rd_idx++;
    chk(tag, got, int'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int    base, fe0, ov0, pe0;

    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    reset    = 1'b1;
    repeat (3) tick();
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ferr", int'(frame_error), 0);
    chk("rst_perr", int'(parity_error), 0);
    chk("rst_ovf", int'(overrun), 0);
    reset = 1'b0;
    repeat (4 * CPB) tick();

    // Single byte, with rx_valid latency of 9.5*CPB+4 cycles from the falling edge
    fork
      send_frame(8'h48, 1'b1, 1'b0);
      begin
        @(negedge uart_rx);
        repeat (9 * CPB + CPB / 2 + 4 + (PAR_EN ? CPB : 0) - 1) @(posedge clock);
        @(negedge clock);
        chk("lat_early", int'(rx_valid), 0);
        @(posedge clock);
        @(negedge clock);
        chk("lat_valid", int'(rx_valid), 1);
        chk("lat_data", int'(rx_data), 8'h48);
      end
    join
    repeat (4) tick();
    chk("b48_count", rx_log.size(), 1);
    expect_byte("b48_byte", 8'h48);
    chk("b48_ferr", fe_cnt, 0);
    chk("b48_ovf", ov_cnt, 0);

    // Back-to-back string
    s = "Hello World!\n";
    base = rx_log.size();
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 1'b0);
    repeat (4) tick();
    chk("str_count", rx_log.size() - base, 13);
    for (int i = 0; i < s.len(); i++) expect_byte("str_byte", s[i]);
    chk("str_peak", max_level, 1);

    // Glitch shorter than half a bit
    base = rx_log.size();
    fe0  = fe_cnt;
    tick();
    uart_rx = 1'b0;
    repeat (5) tick();
    uart_rx = 1'b1;
    repeat (4 * CPB) tick();
    chk("glitch_count", rx_log.size() - base, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (4) tick();
    chk("glitch_next_count", rx_log.size() - base, 1);
    expect_byte("glitch_next", 8'h81);

    // Framing error then recovery
    base = rx_log.size();
    fe0  = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (2 * CPB) tick();
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (4) tick();
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_count", rx_log.size() - base, 1);
    expect_byte("ferr_next", 8'h3C);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (4) tick();
    chk("ovf_level", int'(fifo_level), 16);
    chk("ovf_pulses", ov_cnt - ov0, 1);
    chk("ovf_valid", int'(rx_valid), 1);
    chk("ovf_head", int'(rx_data), 8'h00);
    base = rx_log.size();
    rx_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("drain_count", rx_log.size() - base, 16);
    for (int i = 0; i < 16; i++) expect_byte("drain_byte", 8'(i));
    chk("drain_level", int'(fifo_level), 0);
    chk("drain_valid", int'(rx_valid), 0);
    chk("drain_data", int'(rx_data), 8'h00);

    // Reset asserted during data bit 4 of an aborted frame
    base = rx_log.size();
    fe0  = fe_cnt;
    fork
      send_frame(8'hFF, 1'b1, PAR_EN);
      begin
        @(negedge uart_rx);
        repeat (5 * CPB + CPB / 2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_valid", int'(rx_valid), 0);
      end
    join
    repeat (2 * CPB) tick();
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (4) tick();
    chk("rmid_count", rx_log.size() - base, 1);
    expect_byte("rmid_byte", 8'h55);
    chk("rmid_ferr", fe_cnt - fe0, 0);

`ifdef RVX_UART_RX_PARITY_EN
    // Parity mismatch drops the byte
    base = rx_log.size();
    pe0  = pe_cnt;
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (4) tick();
    chk("par_pulses", pe_cnt - pe0, 1);
    chk("par_count", rx_log.size() - base, 0);
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (4) tick();
    chk("par_good_count", rx_log.size() - base, 1);
    expect_byte("par_good", 8'h03);
    chk("par_pulses_after", pe_cnt - pe0, 1);
`else
    pe0 = 0;
    chk("perr_never", pe_cnt - pe0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
